vga_capture: RTL and testbench
==============================

VGA_CAPTURE -- requirements
Module: vga_capture

Interface
REQ-001 Parameter H_ACTIVE, default 640, expected active pixels per line.
REQ-002 Parameter V_ACTIVE, default 480, expected active lines per frame.
REQ-003 Parameter LOCK_FRAMES, default 2, consecutive clean frames required to assert locked.
REQ-004 clk  in  1  pixel clock; single clock domain; the block SHALL use one clock.
REQ-005 rst  in  1  reset; synchronous and active-high.
REQ-006 h_sync, v_sync  in  1 each  high = inside the active column / active line window.
REQ-007 r_in, g_in, b_in  in  4 each  pixel colour, aligned with the sync inputs.
REQ-008 pix_valid  out  1  one captured pixel this cycle.
REQ-009 pix_x  out  10 and pix_y  out  9  pixel coordinates, origin top-left.
REQ-010 pix_r, pix_g, pix_b  out  4 each  captured colour.
REQ-011 pix_sof  out  1  high with the pixel at x=0, y=0; pix_eol  out  1  high with the pixel at x=H_ACTIVE-1.
REQ-012 frame_done  out  1  one-cycle pulse at frame close; frame_err  out  1  one-cycle pulse at frame close when the frame had a geometry error.
REQ-013 locked  out  1  geometry stable; meas_width  out  11 and meas_lines  out  10  last measured line width and line count.

Function
REQ-014 The block SHALL register all five inputs once before any decision; edges SHALL be detected on the registered syncs.
REQ-015 Latency from an input sample to the corresponding pix_* output SHALL be exactly 2 cycles.
REQ-016 The FSM SHALL have states IDLE, WAIT_SOF, CAPTURE.
REQ-017 IDLE -> WAIT_SOF when registered v_sync is low. This excludes partial frames.
REQ-018 WAIT_SOF -> CAPTURE on a rising edge of v_sync. On that edge, the column counter and line counter SHALL clear to 0 and the frame error flag SHALL clear.
REQ-019 In CAPTURE, each cycle with h_sync=1 and v_sync=1 SHALL emit a pixel at the current (x, y), then increment x.
REQ-020 The pixel SHALL be suppressed (pix_valid=0) if x >= H_ACTIVE or y >= V_ACTIVE. In that case the frame error flag SHALL be set.
REQ-021 The column counter SHALL saturate at 2047 and SHALL NOT wrap.
REQ-022 On a falling edge of h_sync while v_sync=1:
  - meas_width <= column count;
  - error flag set if the count is not H_ACTIVE;
  - x <= 0;
  - y increments, saturating at 1023.
REQ-023 h_sync high while v_sync is low SHALL be ignored: no pixel, no count.
REQ-024 On a falling edge of v_sync in CAPTURE:
  - any open line (h_sync still high) is closed first per REQ-022;
  - meas_lines <= line count;
  - error flag set if the line count is not V_ACTIVE;
  - frame_done pulses;
  - frame_err pulses if the error flag is set;
  - next state is WAIT_SOF.
REQ-025 A simultaneous h_sync fall and v_sync fall SHALL be treated as the normal end of the last line followed by frame close, in the same cycle.
REQ-026 Lock counter:
  - increments on each clean frame close, saturating at LOCK_FRAMES;
  - clears on any erroneous frame close;
  - locked = (counter == LOCK_FRAMES).
REQ-027 pix_* outputs SHALL be 0 whenever pix_valid=0.

Reset
REQ-028 While rst=1, on each clk edge, the following SHALL be 0: state=IDLE, all counters, pix_*, frame_done, frame_err, locked, meas_width, meas_lines, and the input registers.
REQ-029 A reset mid-frame SHALL abort the frame with no frame_done or frame_err pulse. Capture SHALL resume only after v_sync is seen low and then rising.

Structure
REQ-030 Package vga_pkg SHALL hold:
  - H_ACTIVE_DEF=640, V_ACTIVE_DEF=480;
  - the state enum (IDLE, WAIT_SOF, CAPTURE);
  - typedefs for pixel colour (4-bit) and coordinates (10-bit x, 9-bit y).
REQ-031 One sub-module, sync_edge_detect, SHALL register one sync input and produce level, rise and fall outputs. It SHALL be instantiated twice.

Verification
REQ-032 Nominal 640x480 frames with r=x[3:0], g=y[3:0], b=0xA, repeated 3 frames ->
  - 307200 pix_valid per frame, each 2 cycles after its input;
  - pix_sof once per frame; 480 pix_eol per frame;
  - frame_done x3, frame_err never;
  - locked=1 after frame 2;
  - meas_width=640, meas_lines=480.
REQ-033 One line of 641 pixels in frame 2 ->
  - pixel x=640 suppressed;
  - meas_width=641;
  - frame_err pulses at frame 2 close;
  - locked drops to 0, then returns after 2 further clean frames.
REQ-034 A frame with 479 lines -> frame_err pulses; meas_lines=479.
REQ-035 rst released while v_sync=1 mid-frame ->
  - no pix_valid until the next v_sync rise;
  - first frame_done at the close of the first complete frame.
REQ-036 h_sync pulses of 640 cycles while v_sync=0 -> no pix_valid, no frame_done, counters unchanged.
REQ-037 h_sync and v_sync fall in the same cycle at the end of line 479 -> frame closes clean; meas_lines=480; no frame_err.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared defaults, FSM state encoding and pixel field types for the VGA capture block.
package vga_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_SOF,
    CAPTURE
  } state_t;

  typedef logic [3:0] colour_t;
  typedef logic [9:0] coord_x_t;
  typedef logic [8:0] coord_y_t;

endpackage

// File: rtl/sync_edge_detect.sv
// Registers one sync input and reports its registered level plus rising/falling edges.
module sync_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic sync,
  output logic level,
  output logic rise,
  output logic fall
);

  logic prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      level <= 1'b0;
      prev  <= 1'b0;
    end else begin
      level <= sync;
      prev  <= level;
    end
  end

  assign rise = level & ~prev;
  assign fall = ~level & prev;

endmodule

// File: rtl/vga_capture.sv
// Captures active-window pixels from a VGA-style stream, measures frame geometry
// and reports lock once enough consecutive frames match the expected size.
module vga_capture
  import vga_pkg::*;
#(
  parameter int H_ACTIVE    = H_ACTIVE_DEF,
  parameter int V_ACTIVE    = V_ACTIVE_DEF,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        h_sync,
  input  logic        v_sync,
  input  logic [3:0]  r_in,
  input  logic [3:0]  g_in,
  input  logic [3:0]  b_in,
  output logic        pix_valid,
  output logic [9:0]  pix_x,
  output logic [8:0]  pix_y,
  output logic [3:0]  pix_r,
  output logic [3:0]  pix_g,
  output logic [3:0]  pix_b,
  output logic        pix_sof,
  output logic        pix_eol,
  output logic        frame_done,
  output logic        frame_err,
  output logic        locked,
  output logic [10:0] meas_width,
  output logic [9:0]  meas_lines
);

  localparam logic [10:0] H_LIM    = 11'(H_ACTIVE);
  localparam logic [9:0]  V_LIM    = 10'(V_ACTIVE);
  localparam logic [7:0]  LOCK_LIM = 8'(LOCK_FRAMES);

  state_t      state;
  logic        primed;
  colour_t     r_q, g_q, b_q;
  logic [10:0] x_cnt;
  logic [9:0]  y_cnt;
  logic        err_flag;
  logic [7:0]  lock_cnt;

  logic h_lvl, h_rise, h_fall;
  logic v_lvl, v_rise, v_fall;

  sync_edge_detect u_h_edge (
    .clk   (clk),
    .rst   (rst),
    .sync  (h_sync),
    .level (h_lvl),
    .rise  (h_rise),
    .fall  (h_fall)
  );

  sync_edge_detect u_v_edge (
    .clk   (clk),
    .rst   (rst),
    .sync  (v_sync),
    .level (v_lvl),
    .rise  (v_rise),
    .fall  (v_fall)
  );

  logic unused_h_rise;
  assign unused_h_rise = h_rise;

  logic        in_capture, pixel_hit, pixel_ok, line_close, frame_close, frame_bad;
  logic        err_next;
  logic [9:0]  y_next;
  logic [7:0]  lock_next;
  coord_x_t    cur_x;
  coord_y_t    cur_y;

  // A line closes on a normal h fall, or when v drops under an open or just-closing line.
  assign in_capture  = (state == CAPTURE);
  assign pixel_hit   = in_capture && h_lvl && v_lvl;
  assign pixel_ok    = pixel_hit && (x_cnt < H_LIM) && (y_cnt < V_LIM);
  assign line_close  = in_capture && ((h_fall && (v_lvl || v_fall)) || (h_lvl && v_fall));
  assign frame_close = in_capture && v_fall;
  assign y_next      = (line_close && (y_cnt != 10'h3FF)) ? y_cnt + 10'd1 : y_cnt;
  assign err_next    = err_flag | (pixel_hit && !pixel_ok) | (line_close && (x_cnt != H_LIM));
  assign frame_bad   = err_next | (y_next != V_LIM);
  assign lock_next   = frame_bad ? 8'd0 :
                       (lock_cnt == LOCK_LIM) ? lock_cnt : lock_cnt + 8'd1;
  assign cur_x       = x_cnt[9:0];
  assign cur_y       = y_cnt[8:0];

  // primed keeps IDLE from trusting the reset value of the v register as a real low sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      primed     <= 1'b0;
      r_q        <= '0;
      g_q        <= '0;
      b_q        <= '0;
      x_cnt      <= '0;
      y_cnt      <= '0;
      err_flag   <= 1'b0;
      lock_cnt   <= '0;
      locked     <= 1'b0;
      pix_valid  <= 1'b0;
      pix_x      <= '0;
      pix_y      <= '0;
      pix_r      <= '0;
      pix_g      <= '0;
      pix_b      <= '0;
      pix_sof    <= 1'b0;
      pix_eol    <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      meas_width <= '0;
      meas_lines <= '0;
    end else begin
      r_q        <= r_in;
      g_q        <= g_in;
      b_q        <= b_in;
      primed     <= 1'b1;
      pix_valid  <= pixel_ok;
      pix_x      <= pixel_ok ? cur_x : '0;
      pix_y      <= pixel_ok ? cur_y : '0;
      pix_r      <= pixel_ok ? r_q : '0;
      pix_g      <= pixel_ok ? g_q : '0;
      pix_b      <= pixel_ok ? b_q : '0;
      pix_sof    <= pixel_ok && (x_cnt == 11'd0) && (y_cnt == 10'd0);
      pix_eol    <= pixel_ok && (x_cnt == H_LIM - 11'd1);
      frame_done <= frame_close;
      frame_err  <= frame_close && frame_bad;

      case (state)
        IDLE: begin
          if (primed && !v_lvl) state <= WAIT_SOF;
        end
        WAIT_SOF: begin
          if (v_rise) begin
            state    <= CAPTURE;
            x_cnt    <= '0;
            y_cnt    <= '0;
            err_flag <= 1'b0;
          end
        end
        CAPTURE: begin
          if (pixel_hit && (x_cnt != 11'h7FF)) x_cnt <= x_cnt + 11'd1;
          if (line_close) begin
            meas_width <= x_cnt;
            x_cnt      <= '0;
          end
          y_cnt    <= y_next;
          err_flag <= err_next;
          if (frame_close) begin
            meas_lines <= y_next;
            lock_cnt   <= lock_next;
            locked     <= (lock_next == LOCK_LIM);
            state      <= WAIT_SOF;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_capture.sv
// Self-checking bench for vga_capture on a reduced 8x4 geometry with a frame-level model.
module tb_vga_capture;

  localparam int H     = 8;
  localparam int V     = 4;
  localparam int LOCKN = 2;
  localparam int MEM   = 4096;

  typedef struct packed {
    logic        valid;
    logic [9:0]  x;
    logic [8:0]  y;
    logic [3:0]  r;
    logic [3:0]  g;
    logic [3:0]  b;
    logic        sof;
    logic        eol;
    logic        done;
    logic        ferr;
    logic        locked;
    logic [10:0] mw;
    logic [9:0]  ml;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        h_sync = 1'b0;
  logic        v_sync = 1'b0;
  logic [3:0]  r_in = '0;
  logic [3:0]  g_in = '0;
  logic [3:0]  b_in = '0;
  logic        pix_valid;
  logic [9:0]  pix_x;
  logic [8:0]  pix_y;
  logic [3:0]  pix_r, pix_g, pix_b;
  logic        pix_sof, pix_eol, frame_done, frame_err, locked;
  logic [10:0] meas_width;
  logic [9:0]  meas_lines;

  vga_capture #(
    .H_ACTIVE    (H),
    .V_ACTIVE    (V),
    .LOCK_FRAMES (LOCKN)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .h_sync     (h_sync),
    .v_sync     (v_sync),
    .r_in       (r_in),
    .g_in       (g_in),
    .b_in       (b_in),
    .pix_valid  (pix_valid),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .pix_r      (pix_r),
    .pix_g      (pix_g),
    .pix_b      (pix_b),
    .pix_sof    (pix_sof),
    .pix_eol    (pix_eol),
    .frame_done (frame_done),
    .frame_err  (frame_err),
    .locked     (locked),
    .meas_width (meas_width),
    .meas_lines (meas_lines)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Model state: last measured geometry and the count of consecutive clean frames.
  int   m_width, m_lines, m_lock;
  bit   rst_drv;
  obs_t exp_mem [MEM];
  bit   exp_set [MEM];
  int   line_w  [16];
  int   n_checks, n_errors;
  int   cnt_valid, cnt_sof, cnt_eol, cnt_done, cnt_ferr;

  function automatic obs_t idleExp();
    obs_t e;
    e        = '0;
    e.mw     = 11'(m_width);
    e.ml     = 10'(m_lines);
    e.locked = (m_lock == LOCKN);
    return e;
  endfunction

  task automatic checkOutput(input string name, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  task automatic checkCycle();
    obs_t act;
    act.valid  = pix_valid;
    act.x      = pix_x;
    act.y      = pix_y;
    act.r      = pix_r;
    act.g      = pix_g;
    act.b      = pix_b;
    act.sof    = pix_sof;
    act.eol    = pix_eol;
    act.done   = frame_done;
    act.ferr   = frame_err;
    act.locked = locked;
    act.mw     = meas_width;
    act.ml     = meas_lines;
    if (pix_valid)  cnt_valid++;
    if (pix_sof)    cnt_sof++;
    if (pix_eol)    cnt_eol++;
    if (frame_done) cnt_done++;
    if (frame_err)  cnt_ferr++;
    if (cyc < MEM && exp_set[cyc]) begin
      n_checks++;
      if (act !== exp_mem[cyc]) begin
        n_errors++;
        $display("[TB] FAIL cycle %0d outputs (valid,x,y,r,g,b,sof,eol,done,err,lock,mw,ml): got %h expected %h",
                 cyc, act, exp_mem[cyc]);
      end
    end
  endtask

  // One input cycle: drive after the edge, record what must appear two edges later, check at negedge.
  task automatic applyStimulus(input bit h, input bit v, input logic [3:0] r, input logic [3:0] g,
                               input logic [3:0] b, input obs_t e);
    @(posedge clk);
    #1;
    if (rst_drv && !rst && (cyc + 1 < MEM)) begin
      exp_mem[cyc+1] = idleExp();
      exp_set[cyc+1] = 1'b1;
    end
    rst    = rst_drv;
    h_sync = h;
    v_sync = v;
    r_in   = r;
    g_in   = g;
    b_in   = b;
    if (cyc + 2 < MEM) begin
      exp_mem[cyc+2] = e;
      exp_set[cyc+2] = 1'b1;
    end
    @(negedge clk);
    checkCycle();
  endtask

  task automatic idleCycles(input int n);
    for (int k = 0; k < n; k++) applyStimulus(1'b0, 1'b0, 4'h0, 4'h0, 4'h0, idleExp());
  endtask

  // Whole frame of n_lines lines using line_w[]; rst_on/rst_off pick lines where reset toggles.
  task automatic applyFrame(input int n_lines, input bit simul_end, input bit capture,
                            input int rst_on, input int rst_off);
    bit         cap, bad;
    obs_t       e;
    logic [3:0] cr, cg;
    cap = capture;
    bad = (n_lines != V);
    idleCycles(3);
    for (int l = 0; l < n_lines; l++) begin
      if (l == rst_on) begin
        rst_drv = 1'b1;
        cap     = 1'b0;
        m_width = 0;
        m_lines = 0;
        m_lock  = 0;
      end
      if (l == rst_off) rst_drv = 1'b0;
      repeat (2) applyStimulus(1'b0, 1'b1, 4'h0, 4'h0, 4'h0, idleExp());
      for (int i = 0; i < line_w[l]; i++) begin
        cr = i[3:0];
        cg = l[3:0];
        e  = idleExp();
        if (cap && i < H && l < V) begin
          e.valid = 1'b1;
          e.x     = 10'(i);
          e.y     = 9'(l);
          e.r     = cr;
          e.g     = cg;
          e.b     = 4'hA;
          e.sof   = (i == 0 && l == 0);
          e.eol   = (i == H - 1);
        end
        applyStimulus(1'b1, 1'b1, cr, cg, 4'hA, e);
      end
      if (cap) begin
        m_width = line_w[l];
        if (line_w[l] != H) bad = 1'b1;
      end
      if (!(simul_end && l == n_lines - 1))
        applyStimulus(1'b0, 1'b1, 4'h0, 4'h0, 4'h0, idleExp());
    end
    e = idleExp();
    if (cap) begin
      m_lines = n_lines;
      if (bad) m_lock = 0;
      else if (m_lock < LOCKN) m_lock++;
      e      = idleExp();
      e.done = 1'b1;
      e.ferr = bad;
    end
    applyStimulus(1'b0, 1'b0, 4'h0, 4'h0, 4'h0, e);
  endtask

  task automatic applyHOnly();
    repeat (2) begin
      repeat (2) applyStimulus(1'b0, 1'b0, 4'h0, 4'h0, 4'h0, idleExp());
      repeat (H) applyStimulus(1'b1, 1'b0, 4'h5, 4'h6, 4'h7, idleExp());
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    m_width = 0;
    m_lines = 0;
    m_lock  = 0;
    rst_drv = 1'b1;
    n_checks = 0;
    n_errors = 0;
    for (int k = 0; k < 16; k++) line_w[k] = H;

    idleCycles(3);
    checkOutput("reset pix_valid", int'(pix_valid), 0);
    checkOutput("reset frame_done", int'(frame_done), 0);
    checkOutput("reset locked", int'(locked), 0);
    checkOutput("reset meas_width", int'(meas_width), 0);
    checkOutput("reset meas_lines", int'(meas_lines), 0);

    rst_drv = 1'b0;
    idleCycles(4);

    applyFrame(V, 1'b0, 1'b1, -1, -1);
    idleCycles(3);
    checkOutput("frame1 done count", cnt_done, 1);
    checkOutput("frame1 locked", int'(locked), 0);
    applyFrame(V, 1'b0, 1'b1, -1, -1);
    idleCycles(3);
    checkOutput("frame2 locked", int'(locked), 1);
    applyFrame(V, 1'b0, 1'b1, -1, -1);
    idleCycles(3);
    checkOutput("nominal valid count", cnt_valid, 96);
    checkOutput("nominal sof count", cnt_sof, 3);
    checkOutput("nominal eol count", cnt_eol, 12);
    checkOutput("nominal done count", cnt_done, 3);
    checkOutput("nominal err count", cnt_ferr, 0);
    checkOutput("nominal meas_width", int'(meas_width), 8);
    checkOutput("nominal meas_lines", int'(meas_lines), 4);

    line_w[3] = H + 1;
    applyFrame(V, 1'b0, 1'b1, -1, -1);
    line_w[3] = H;
    idleCycles(3);
    checkOutput("wide line err count", cnt_ferr, 1);
    checkOutput("wide line locked", int'(locked), 0);
    checkOutput("wide line meas_width", int'(meas_width), 9);
    checkOutput("wide line valid count", cnt_valid, 128);

    applyFrame(V, 1'b0, 1'b1, -1, -1);
    idleCycles(3);
    checkOutput("relock after 1 clean", int'(locked), 0);
    applyFrame(V, 1'b0, 1'b1, -1, -1);
    idleCycles(3);
    checkOutput("relock after 2 clean", int'(locked), 1);

    applyFrame(V - 1, 1'b0, 1'b1, -1, -1);
    idleCycles(3);
    checkOutput("short frame err count", cnt_ferr, 2);
    checkOutput("short frame meas_lines", int'(meas_lines), 3);
    checkOutput("short frame locked", int'(locked), 0);

    applyHOnly();
    idleCycles(3);
    checkOutput("h-only valid count", cnt_valid, 216);
    checkOutput("h-only done count", cnt_done, 7);

    applyFrame(V, 1'b1, 1'b1, -1, -1);
    idleCycles(3);
    checkOutput("joint fall done count", cnt_done, 8);
    checkOutput("joint fall err count", cnt_ferr, 2);
    checkOutput("joint fall meas_lines", int'(meas_lines), 4);
    checkOutput("joint fall meas_width", int'(meas_width), 8);

    applyFrame(V, 1'b0, 1'b1, 1, 2);
    idleCycles(3);
    checkOutput("aborted frame done count", cnt_done, 8);
    checkOutput("aborted frame meas_lines", int'(meas_lines), 0);
    checkOutput("aborted frame valid count", cnt_valid, 256);

    applyFrame(V, 1'b0, 1'b1, -1, -1);
    idleCycles(3);
    checkOutput("post-reset done count", cnt_done, 9);
    checkOutput("post-reset err count", cnt_ferr, 2);
    checkOutput("post-reset locked", int'(locked), 0);
    checkOutput("post-reset valid count", cnt_valid, 288);
    applyFrame(V, 1'b0, 1'b1, -1, -1);
    idleCycles(3);
    checkOutput("post-reset relock", int'(locked), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
